// File: rtl/stream_pkg.sv
// Shared types and default parameters for the stream_checker FIFO read sequencer.
package stream_pkg;

    localparam int unsigned K_DEFAULT     = 32'd4;
    localparam int unsigned BURST_DEFAULT = 32'd4;
    localparam int unsigned PAUSE_DEFAULT = 32'd2;
    localparam int unsigned CW_DEFAULT    = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/stream_checker_seq_check.sv
// Incrementing-sequence checker for captured FIFO words; present only when
// STREAM_SEQ_CHECK_EN is defined.
`ifdef STREAM_SEQ_CHECK_EN
module seq_check
    import stream_pkg::*;
#(
    parameter int unsigned K  = K_DEFAULT,
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cap,
    input  logic [K-1:0]  data,
    output logic [CW-1:0] err_cnt,
    output logic          err_flag
);

    logic          first_seen_r;
    logic [K-1:0]  expected_r;
    logic [CW-1:0] err_cnt_r;
    logic          err_flag_r;

    // First capture only primes the expectation; every capture reloads it so the check resynchronises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_seen_r <= 1'b0;
            expected_r   <= {K{1'b0}};
            err_cnt_r    <= {CW{1'b0}};
            err_flag_r   <= 1'b0;
        end else if (cap) begin
            first_seen_r <= 1'b1;
            expected_r   <= data + K'(1'b1);
            if (first_seen_r && (data != expected_r)) begin
                err_flag_r <= 1'b1;
                if (err_cnt_r != {CW{1'b1}}) begin
                    err_cnt_r <= err_cnt_r + CW'(1'b1);
                end
            end
        end
    end

    assign err_cnt  = err_cnt_r;
    assign err_flag = err_flag_r;

endmodule
`endif

// File: rtl/stream_checker.sv
// Burst-limited FIFO reader with word capture and counting; the sequence
// checker is compiled in when STREAM_SEQ_CHECK_EN is defined.
module stream_checker
    import stream_pkg::*;
#(
    parameter int unsigned K     = K_DEFAULT,
    parameter int unsigned BURST = BURST_DEFAULT,
    parameter int unsigned PAUSE = PAUSE_DEFAULT,
    parameter int unsigned CW    = CW_DEFAULT
) (
    input  logic          read_clk,
    input  logic          rst,
    input  logic          empty,
    input  logic [K-1:0]  data,
    output logic          read,
    output logic [K-1:0]  last_word,
    output logic [CW-1:0] word_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err_flag,
    output logic          busy
);

    localparam int unsigned BW = cnt_width(BURST);
    localparam int unsigned PW = cnt_width(PAUSE);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 32'd1);
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE - 32'd1);
    localparam logic          PAUSE_EN   = (PAUSE != 32'd0);

    state_e        state_r, state_s;
    logic [BW-1:0] burst_cnt_r, burst_cnt_s;
    logic [PW-1:0] pause_cnt_r, pause_cnt_s;
    logic          read_s;
    logic          rd_q_r;
    logic          busy_r;
    logic [K-1:0]  last_word_r;
    logic [CW-1:0] word_cnt_r;

    // Next-state, burst/pause counting and the pop request.
    always_comb begin
        state_s     = state_r;
        burst_cnt_s = burst_cnt_r;
        pause_cnt_s = pause_cnt_r;
        read_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (!empty) begin
                    read_s = 1'b1;
                    if (burst_cnt_r == BURST_LAST) begin
                        burst_cnt_s = {BW{1'b0}};
                        pause_cnt_s = {PW{1'b0}};
                        if (PAUSE_EN) begin
                            state_s = ST_PAUSE;
                        end else begin
                            state_s = ST_READ;
                        end
                    end else begin
                        burst_cnt_s = burst_cnt_r + BW'(1'b1);
                    end
                end else if (burst_cnt_r == {BW{1'b0}}) begin
                    state_s = ST_IDLE;
                end else begin
                    // Mid-burst underflow: wait with the burst count frozen.
                    state_s = ST_READ;
                end
            end
            ST_PAUSE: begin
                if (pause_cnt_r == PAUSE_LAST) begin
                    pause_cnt_s = {PW{1'b0}};
                    state_s     = ST_READ;
                end else begin
                    pause_cnt_s = pause_cnt_r + PW'(1'b1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                burst_cnt_s = {BW{1'b0}};
                pause_cnt_s = {PW{1'b0}};
            end
        endcase
    end

    // FSM state, counters and busy flag.
    always_ff @(posedge read_clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            burst_cnt_r <= {BW{1'b0}};
            pause_cnt_r <= {PW{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            burst_cnt_r <= burst_cnt_s;
            pause_cnt_r <= pause_cnt_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Data arrives one cycle after the pop, so capture follows the delayed read.
    always_ff @(posedge read_clk or negedge rst) begin
        if (!rst) begin
            rd_q_r      <= 1'b0;
            last_word_r <= {K{1'b0}};
            word_cnt_r  <= {CW{1'b0}};
        end else begin
            rd_q_r <= read_s;
            if (rd_q_r) begin
                last_word_r <= data;
                word_cnt_r  <= word_cnt_r + CW'(1'b1);
            end
        end
    end

    assign read      = read_s;
    assign busy      = busy_r;
    assign last_word = last_word_r;
    assign word_cnt  = word_cnt_r;

`ifdef STREAM_SEQ_CHECK_EN
    seq_check #(
        .K  (K),
        .CW (CW)
    ) u_seq_check (
        .clk      (read_clk),
        .rst_n    (rst),
        .cap      (rd_q_r),
        .data     (data),
        .err_cnt  (err_cnt),
        .err_flag (err_flag)
    );
`else
    assign err_cnt  = {CW{1'b0}};
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Self-checking bench for stream_checker: FIFO model, transaction-level reference and vector table.
module tb_stream_checker;

    localparam int K     = 4;
    localparam int BURST = 4;
    localparam int PAUSE = 2;
    localparam int CW    = 8;
`ifdef STREAM_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic          read_clk = 1'b0;
    logic          rst;
    logic          empty;
    logic [K-1:0]  data;
    logic          read;
    logic [K-1:0]  last_word;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] err_cnt;
    logic          err_flag;
    logic          busy;

    always #5 read_clk = ~read_clk;

    stream_checker #(.K(K), .BURST(BURST), .PAUSE(PAUSE), .CW(CW)) dut (
        .read_clk  (read_clk),
        .rst       (rst),
        .empty     (empty),
        .data      (data),
        .read      (read),
        .last_word (last_word),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [K-1:0] fifo[$];

    // reference model: burst/pause accounting and a list-level view of captured words
    bit           m_active;
    int           m_nread;
    int           m_pause;
    bit           m_pend;
    logic [K-1:0] m_pend_word;
    bit           m_first;
    logic [K-1:0] m_prev;
    logic [K-1:0] m_last;
    int           m_wcnt;
    int           m_ecnt;
    bit           m_flag;

    typedef struct {
        logic empty;
        logic exp_read;
        logic exp_busy;
    } vec_t;
    vec_t tbl[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_nread = 0; m_pause = 0; m_pend = 1'b0; m_pend_word = '0;
        m_first = 1'b0; m_prev = '0; m_last = '0; m_wcnt = 0; m_ecnt = 0; m_flag = 1'b0;
    endtask

    task automatic model_capture(input logic [K-1:0] w);
        m_wcnt = (m_wcnt + 1) % (1 << CW);
        m_last = w;
        if (m_first && SEQ_EN && (int'(w) != (int'(m_prev) + 1) % (1 << K))) begin
            m_flag = 1'b1;
            if (m_ecnt < (1 << CW) - 1) m_ecnt = m_ecnt + 1;
        end
        m_first = 1'b1;
        m_prev  = w;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".last_word"}, 32'(last_word), 32'(m_last));
        check({tag, ".word_cnt"},  32'(word_cnt),  32'(m_wcnt));
        check({tag, ".err_cnt"},   32'(err_cnt),   32'(m_ecnt));
        check({tag, ".err_flag"},  32'(err_flag),  32'(m_flag));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".read"},      32'(read),      32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".last_word"}, 32'(last_word), 32'd0);
        check({tag, ".word_cnt"},  32'(word_cnt),  32'd0);
        check({tag, ".err_cnt"},   32'(err_cnt),   32'd0);
        check({tag, ".err_flag"},  32'(err_flag),  32'd0);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic run_cycle(input bit emp, output bit rd_o, output bit busy_o);
        bit           exp_rd;
        logic [K-1:0] w;
        empty = emp;
        #1;
        exp_rd = m_active && (m_pause == 0) && !emp;
        rd_o   = read;
        busy_o = busy;
        check("read", 32'(read), 32'(exp_rd));
        check("busy", 32'(busy), 32'(m_active));
        @(posedge read_clk);
        if (!m_active) begin
            if (!emp) m_active = 1'b1;
        end else if (m_pause > 0) begin
            m_pause--;
        end else if (exp_rd) begin
            m_nread++;
            if (m_nread == BURST) begin
                m_nread = 0;
                m_pause = PAUSE;
            end
        end else if (m_nread == 0) begin
            m_active = 1'b0;
        end
        #1;
        if (m_pend) model_capture(m_pend_word);
        m_pend = 1'b0;
        if (exp_rd) begin
            if (fifo.size() > 0) w = fifo.pop_front();
            else w = K'($urandom_range(0, 15));
            data = w;
            m_pend = 1'b1;
            m_pend_word = w;
        end
        check_outputs("cyc");
        @(negedge read_clk);
    endtask

    task automatic run_fifo(input int n);
        bit rd, bz;
        for (int i = 0; i < n; i++) run_cycle(fifo.size() == 0, rd, bz);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        empty = 1'b1;
        data = '0;
        fifo.delete();
        model_reset();
        #1;
        check_all_zero("rst");
        repeat (2) @(negedge read_clk);
        rst = 1'b1;
    endtask

    initial begin
        bit rd, bz;
        logic [K-1:0] seqv;
        tbl = '{
            '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b0, 1'b0}
        };
        rst = 1'b0;
        empty = 1'b1;
        data = '0;
        model_reset();
        repeat (2) @(negedge read_clk);
        check_all_zero("por");
        rst = 1'b1;

        // words 0..7 continuously available: 4 reads, 2 idle, 4 reads
        for (int i = 0; i < 8; i++) fifo.push_back(K'(i));
        for (int i = 0; i < 15; i++) begin
            run_cycle(tbl[i].empty, rd, bz);
            check($sformatf("tbl%0d.read", i), 32'(rd), 32'(tbl[i].exp_read));
            check($sformatf("tbl%0d.busy", i), 32'(bz), 32'(tbl[i].exp_busy));
        end
        check("burst.last_word", 32'(last_word), 32'd7);
        check("burst.word_cnt",  32'(word_cnt),  32'd8);
        check("burst.err_cnt",   32'(err_cnt),   32'd0);

        // empty toggling during bursts
        do_reset();
        for (int i = 0; i < 16; i++) fifo.push_back(K'(i));
        for (int i = 0; i < 40; i++) run_cycle((i % 2 == 0) || (fifo.size() == 0), rd, bz);

        // 3,4,9,10: one error on the third word, resynchronised on the fourth
        do_reset();
        fifo = '{4'd3, 4'd4, 4'd9, 4'd10};
        run_fifo(12);
        check("seq3.err_cnt",  32'(err_cnt),  SEQ_EN ? 32'd1 : 32'd0);
        check("seq3.err_flag", 32'(err_flag), SEQ_EN ? 32'd1 : 32'd0);
        check("seq3.word_cnt", 32'(word_cnt), 32'd4);

        // wrap-around 14,15,0,1 is a valid sequence
        do_reset();
        fifo = '{4'd14, 4'd15, 4'd0, 4'd1};
        run_fifo(12);
        check("wrap.err_cnt",   32'(err_cnt),   32'd0);
        check("wrap.last_word", 32'(last_word), 32'd1);

        // 1,5: flagged only when the checker is built in
        do_reset();
        fifo = '{4'd1, 4'd5};
        run_fifo(10);
        check("pair.err_cnt",  32'(err_cnt),  SEQ_EN ? 32'd1 : 32'd0);
        check("pair.err_flag", 32'(err_flag), SEQ_EN ? 32'd1 : 32'd0);
        check("pair.word_cnt", 32'(word_cnt), 32'd2);

        // reset asserted during the second read of a burst
        do_reset();
        for (int i = 0; i < 8; i++) fifo.push_back(K'(i));
        run_cycle(1'b0, rd, bz);
        run_cycle(1'b0, rd, bz);
        empty = 1'b0;
        #1;
        check("midrst.read_before", 32'(read), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge read_clk);
        #1;
        check_all_zero("midrst_edge");
        @(negedge read_clk);
        model_reset();
        rst = 1'b1;
        run_fifo(20);

        // randomized traffic: in-order words, then arbitrary words to wrap/saturate counters
        do_reset();
        seqv = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                fifo.push_back(seqv);
                seqv = seqv + 4'd1;
            end
            run_cycle((fifo.size() == 0) || ($urandom_range(0, 4) == 0), rd, bz);
        end
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 3) != 0) fifo.push_back(K'($urandom_range(0, 15)));
            run_cycle((fifo.size() == 0) || ($urandom_range(0, 5) == 0), rd, bz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_checker.md
STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 Parameter K, default 4: data word width; the block SHALL match the FIFO data width.
REQ-002 Parameter BURST, default 4: maximum reads per burst; the block SHALL require BURST >= 1.
REQ-003 Parameter PAUSE, default 2: idle cycles between bursts; PAUSE = 0 SHALL mean no pause.
REQ-004 Parameter CW, default 8: width of the word and error counters.
REQ-005 read_clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1: reset, asynchronous assert, active-low (0 = reset).
REQ-007 empty  input  1: FIFO empty flag, synchronous to read_clk.
REQ-008 data  input  K: FIFO dout, valid the cycle after read is sampled high.
REQ-009 read  output  1: pop request to the FIFO.
REQ-010 last_word  output  K: most recently captured word.
REQ-011 word_cnt  output  CW: number of words captured since reset.
REQ-012 err_cnt  output  CW: number of sequence mismatches since reset.
REQ-013 err_flag  output  1: sticky mismatch indicator.
REQ-014 busy  output  1: high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, READ and PAUSE.
REQ-016 IDLE -> READ SHALL occur when empty = 0.
REQ-017 In READ, read SHALL equal !empty; each asserted read SHALL increment burst_cnt.
REQ-018 In READ, when empty = 1 and burst_cnt = 0, the FSM SHALL return to IDLE.
REQ-019 In READ, when empty = 1 and burst_cnt > 0, the FSM SHALL hold READ with burst_cnt frozen.
REQ-020 When the BURST-th read of a burst issues: burst_cnt SHALL clear; the next state SHALL be PAUSE if PAUSE > 0, else READ.
REQ-021 PAUSE SHALL last exactly PAUSE cycles with read = 0, then go to READ.
REQ-022 read SHALL be 0 in IDLE and PAUSE; the block SHALL never assert read while empty = 1.
REQ-023 A 1-bit rd_q flag SHALL register read; when rd_q = 1, data SHALL be captured into last_word.
REQ-024 Each capture SHALL increment word_cnt, wrapping modulo 2^CW.
REQ-025 The first capture after reset SHALL load expected = data + 1 (mod 2^K) without comparison.
REQ-026 On each later capture, data != expected SHALL increment err_cnt (saturating at 2^CW-1) and set err_flag.
REQ-027 Every later capture SHALL reload expected = data + 1 (mod 2^K), so the check resynchronises after an error.
REQ-028 A K-bit all-ones word followed by 0 SHALL be treated as correct (wrap-around).
REQ-029 Capture, counting and checking of an in-flight word (rd_q = 1) SHALL complete even if the FSM enters PAUSE or IDLE.

Reset
REQ-030 While rst = 0, the block SHALL hold state = IDLE and set burst_cnt, pause counter, rd_q, read, last_word, word_cnt, err_cnt, err_flag, busy and expected to 0, and clear the first-word marker.
REQ-031 Reset asserted mid-burst SHALL drop read in the same cycle (asynchronously) and discard any in-flight capture.
REQ-032 After rst rises, the first read SHALL occur no earlier than the first clock edge with empty = 0.

Configuration
REQ-033 With macro STREAM_SEQ_CHECK_EN defined, the sequence checker (expected register, err_cnt, err_flag) SHALL be compiled in as specified.
REQ-034 Without STREAM_SEQ_CHECK_EN, err_cnt and err_flag SHALL be tied to 0, the expected register SHALL be omitted, and all other behaviour SHALL be unchanged.

Structure
REQ-035 A shared package stream_pkg SHALL hold the FSM state enum (IDLE, READ, PAUSE) and the default values for K, BURST, PAUSE and CW.
REQ-036 The checker SHALL be one sub-module, seq_check: inputs capture strobe and data; outputs err_cnt and err_flag. It SHALL be instantiated only under STREAM_SEQ_CHECK_EN.

Verification
REQ-037 Reset, then FIFO holding 0..7 continuously non-empty -> read pattern 4 high, 2 low, 4 high; last_word = 7; word_cnt = 8; err_cnt = 0.
REQ-038 empty toggles every cycle during a burst -> read never high while empty = 1; burst boundary occurs after the 4th actual read.
REQ-039 Sequence 3,4,9,10 -> err_cnt = 1 and err_flag = 1 after the third capture; the fourth word is not flagged.
REQ-040 Sequence 14,15,0,1 with K = 4 -> err_cnt = 0.
REQ-041 rst pulled low on the 2nd read of a burst -> read = 0 immediately; all outputs 0; after release, the block restarts from IDLE.
REQ-042 Build without STREAM_SEQ_CHECK_EN, sequence 1,5 -> err_cnt = 0, err_flag = 0, word_cnt = 2.
